execute_stage: RTL and testbench
================================

Name: execute_stage

Overview:
- Pipeline stage 3. Consumes the decode-stage bundle (WB/MEM/EXE control, RS/RT/RD, dataA/dataB, sign-extended imm).
- Contains the ID/EX register, operand forwarding, the ALU, a 32-cycle iterative multiplier and the EX/MEM register.
- Feeds the memory stage and drives back-pressure (busy) to fetch/decode.

Parameters:
- WIDTH, 32, datapath width.
- MUL_CYCLES, 32, multiplier iterations; must equal WIDTH.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset; synchronous, active-high.
- flush_in  input  1  loads a bubble into ID/EX on this edge (hazard/branch unit).
- WB_in  input  2  [1]=RegWrite, [0]=MemtoReg.
- MEM_in  input  3  [2]=Branch, [1]=MemRead, [0]=MemWrite.
- EXE_in  input  4  [3]=RegDst, [2:1]=ALUOp, [0]=ALUSrc.
- RS_in, RT_in, RD_in  input  5 each  register specifiers.
- dataA_in, dataB_in  input  32  register-file read data.
- imm_in  input  32  sign-extended immediate; funct = imm[5:0], shamt = imm[10:6].
- wb_regwrite_in  input  1  MEM/WB RegWrite.
- wb_rd_in  input  5  MEM/WB destination.
- wb_data_in  input  32  MEM/WB write-back data.
- busy_out  output  1  multiply in progress; upstream must hold.
- WB_out  output  2  registered WB control.
- MEM_out  output  3  registered MEM control.
- alu_out  output  32  registered result.
- store_out  output  32  registered forwarded rt value, used for stores.
- dest_out  output  5  registered destination register.
- zero_out  output  1  registered (result == 0).

Behaviour:
- Reset: every output and every ID/EX and multiplier register is 0; FSM enters IDLE.
- ID/EX capture: on each edge with busy_out=0, ID/EX takes the *_in values. flush_in=1 forces WB=0, MEM=0 and EXE=0; data fields are don't-care.
- ID/EX hold: while busy_out=1, ID/EX holds and flush_in is ignored.
- Latency: a bundle presented before edge N appears on the EX/MEM outputs after edge N+1. Multiply takes 1+MUL_CYCLES edges to reach the outputs.
- Forwarding, applied to operand A (from RS) and operand B (from RT):
  - Index 0 never forwards.
  - Priority 1: EX/MEM, when WB_out[1]=1 and dest_out matches the index; data = alu_out.
  - Priority 2: MEM/WB, when wb_regwrite_in=1 and wb_rd_in matches; data = wb_data_in.
  - Otherwise the latched dataA/dataB is used.
- ALU B input = ALUSrc ? imm : forwarded B. store_out = forwarded B.
- dest = RegDst ? RD : RT.
- ALUOp decode:
  - 00: add.
  - 01: subtract.
  - 11: OR with imm.
  - 10: by funct:
    - 0x20 add, 0x22 sub, 0x24 and, 0x25 or.
    - 0x2A slt, signed; result 1 or 0.
    - 0x00 sll B by shamt.
    - 0x18 mult.
    - Any other funct gives result 0.
- Arithmetic: wraps modulo 2^32; no overflow trap.
- FSM IDLE → MUL: on an edge with a valid R-type funct 0x18 in ID/EX and FSM in IDLE:
  - Latch the multiplicand/multiplier (forwarded values).
  - Clear the accumulator and set the counter to 0.
  - busy_out=1 from the next cycle.
  - EX/MEM loads a bubble (WB=0, MEM=0, alu=0).
- FSM MUL → DONE: one shift-add iteration per edge. After MUL_CYCLES iterations the low 32 bits of the product are complete; go to DONE.
- FSM DONE → IDLE: on one edge, EX/MEM loads WB/MEM/dest of the held mult plus the product; busy_out drops to 0.
  - The next ID/EX capture takes the instruction upstream held during busy.
  - The mult is not re-executed; the DONE edge also marks the ID/EX entry consumed.
- While in MUL: each EX/MEM edge writes a bubble.
- zero_out reflects the registered result, including the product.
- Reset mid-multiply: abort, IDLE, busy_out=0, outputs 0.
- Simultaneous flush_in and mult capture: flush wins and no multiply starts.

Test Plan:
- Forward priority:
  - Stimulus: add r3=r1+r2 (5+7); next cycle sub r4=r3-r1 with stale dataA=0; wb_rd_in=3, wb_data_in=99, wb_regwrite_in=1.
  - Required: alu_out=12 then 7 (EX/MEM wins over MEM/WB).
- Register zero:
  - Stimulus: dest 0 with RegWrite, followed by a consumer of r0.
  - Required: no forwarding; the latched value is used.
- Immediate/branch path:
  - Stimulus: lw-style ALUOp=00, ALUSrc=1, A=0x100, imm=0xFFFFFFFC.
  - Required: alu_out=0xFC, MEM_out passes 3'b010.
  - Stimulus: beq-style ALUOp=01, A=B=5.
  - Required: zero_out=1.
- slt signed and sll:
  - Stimulus: slt with A=0xFFFFFFFF, B=1.
  - Required: alu_out=1.
  - Stimulus: sll with B=1, shamt=31.
  - Required: 0x80000000.
- Multiply:
  - Stimulus: A=0x10001, B=0x10001.
  - Required: busy_out high exactly 33 cycles, bubbles on EX/MEM, then alu_out=0x00020001 with WB_out=2'b10.
  - Stimulus: the following instruction held on the inputs.
  - Required: it executes exactly once.
- Reset/flush:
  - Stimulus: rst asserted at multiply iteration 10.
  - Required: busy_out=0 and all outputs 0 next cycle.
  - Stimulus: flush_in with a valid add.
  - Required: WB_out=0, MEM_out=0.

Source files
------------

// File: rtl/execute_stage.sv
// execute_stage: pipeline stage 3 (execute).
//
// Holds the ID/EX register, operand forwarding, the ALU, a shift-add
// multiplier that runs one iteration per clock, and the EX/MEM register.
//
// Ports
//   clk, rst                  rising-edge clock, synchronous active-high reset
//   flush_in                  loads a bubble into ID/EX on this edge
//   WB_in/MEM_in/EXE_in       control bundle from decode
//   RS_in/RT_in/RD_in         register specifiers
//   dataA_in/dataB_in/imm_in  operands and sign-extended immediate
//   wb_regwrite_in/wb_rd_in/wb_data_in  MEM/WB write-back (forwarding source)
//   busy_out                  multiply in progress, upstream must hold
//   WB_out/MEM_out/alu_out/store_out/dest_out/zero_out  EX/MEM register
//
// Handshake: upstream presents a bundle and keeps it on the inputs until an
// edge that sees busy_out=0 and does not start a multiply. The edge that
// starts a multiply keeps the mult in ID/EX, so the bundle presented for that
// edge stays upstream for the whole busy period and is taken by the first
// capture after busy_out drops.
module execute_stage #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_in,
  input  logic [1:0]       WB_in,
  input  logic [2:0]       MEM_in,
  input  logic [3:0]       EXE_in,
  input  logic [4:0]       RS_in,
  input  logic [4:0]       RT_in,
  input  logic [4:0]       RD_in,
  input  logic [WIDTH-1:0] dataA_in,
  input  logic [WIDTH-1:0] dataB_in,
  input  logic [WIDTH-1:0] imm_in,
  input  logic             wb_regwrite_in,
  input  logic [4:0]       wb_rd_in,
  input  logic [WIDTH-1:0] wb_data_in,
  output logic             busy_out,
  output logic [1:0]       WB_out,
  output logic [2:0]       MEM_out,
  output logic [WIDTH-1:0] alu_out,
  output logic [WIDTH-1:0] store_out,
  output logic [4:0]       dest_out,
  output logic             zero_out
);
  localparam int CW = $clog2(MUL_CYCLES) + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DONE = 2'd2} state_t;
  state_t state, state_next;

  // ID/EX register
  logic [1:0]       ie_wb;
  logic [2:0]       ie_mem;
  logic [3:0]       ie_exe;
  logic [4:0]       ie_rs, ie_rt, ie_rd;
  logic [WIDTH-1:0] ie_a, ie_b, ie_imm;

  // multiplier datapath
  logic [WIDTH-1:0] mcand, mplier, acc;
  logic [CW-1:0]    cnt;

  logic [WIDTH-1:0] fwd_a, fwd_b, alu_b, alu_res;
  logic [5:0]       funct;
  logic [4:0]       shamt;
  logic [4:0]       dest;
  logic             is_mult, mul_start, hold_idex;

  assign funct     = ie_imm[5:0];
  assign shamt     = ie_imm[10:6];
  assign dest      = ie_exe[3] ? ie_rd : ie_rt;
  assign is_mult   = (ie_exe[2:1] == 2'b10) && (funct == 6'h18);
  assign mul_start = (state == IDLE) && is_mult;
  assign busy_out  = (state != IDLE);
  // The start edge also keeps ID/EX so the mult's WB/MEM/dest survive.
  assign hold_idex = busy_out || mul_start;

  // Forwarding: EX/MEM first, then MEM/WB; r0 is never forwarded.
  always_comb begin
    fwd_a = ie_a;
    if (ie_rs != 5'd0 && WB_out[1] && dest_out == ie_rs)
      fwd_a = alu_out;
    else if (ie_rs != 5'd0 && wb_regwrite_in && wb_rd_in == ie_rs)
      fwd_a = wb_data_in;
  end

  always_comb begin
    fwd_b = ie_b;
    if (ie_rt != 5'd0 && WB_out[1] && dest_out == ie_rt)
      fwd_b = alu_out;
    else if (ie_rt != 5'd0 && wb_regwrite_in && wb_rd_in == ie_rt)
      fwd_b = wb_data_in;
  end

  assign alu_b = ie_exe[0] ? ie_imm : fwd_b;

  always_comb begin
    alu_res = '0;
    case (ie_exe[2:1])
      2'b00: alu_res = fwd_a + alu_b;
      2'b01: alu_res = fwd_a - alu_b;
      2'b11: alu_res = fwd_a | ie_imm;
      default: begin
        case (funct)
          6'h20:   alu_res = fwd_a + alu_b;
          6'h22:   alu_res = fwd_a - alu_b;
          6'h24:   alu_res = fwd_a & alu_b;
          6'h25:   alu_res = fwd_a | alu_b;
          6'h2A:   alu_res = {{(WIDTH-1){1'b0}}, ($signed(fwd_a) < $signed(alu_b))};
          6'h00:   alu_res = alu_b << shamt;
          default: alu_res = '0;
        endcase
      end
    endcase
  end

  // FSM
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (mul_start) state_next = MUL;
      MUL:     if (cnt == CW'(MUL_CYCLES - 1)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ID/EX
  always_ff @(posedge clk) begin
    if (rst) begin
      ie_wb  <= '0;
      ie_mem <= '0;
      ie_exe <= '0;
      ie_rs  <= '0;
      ie_rt  <= '0;
      ie_rd  <= '0;
      ie_a   <= '0;
      ie_b   <= '0;
      ie_imm <= '0;
    end else if (state == DONE) begin
      // The mult retires on this edge; turn its entry into a bubble so it
      // cannot start again once the FSM is back in IDLE.
      ie_wb  <= '0;
      ie_mem <= '0;
      ie_exe <= '0;
    end else if (!hold_idex) begin
      ie_wb  <= flush_in ? 2'b0 : WB_in;
      ie_mem <= flush_in ? 3'b0 : MEM_in;
      ie_exe <= flush_in ? 4'b0 : EXE_in;
      ie_rs  <= RS_in;
      ie_rt  <= RT_in;
      ie_rd  <= RD_in;
      ie_a   <= dataA_in;
      ie_b   <= dataB_in;
      ie_imm <= imm_in;
    end
  end

  // Shift-add multiplier, low WIDTH bits only.
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else if (mul_start) begin
      mcand  <= fwd_a;
      mplier <= fwd_b;
      acc    <= '0;
      cnt    <= '0;
    end else if (state == MUL) begin
      acc    <= acc + (mplier[0] ? mcand : '0);
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CW'(1);
    end
  end

  // EX/MEM
  always_ff @(posedge clk) begin
    if (rst) begin
      WB_out    <= '0;
      MEM_out   <= '0;
      alu_out   <= '0;
      store_out <= '0;
      dest_out  <= '0;
      zero_out  <= 1'b0;
    end else if (state == DONE) begin
      WB_out    <= ie_wb;
      MEM_out   <= ie_mem;
      alu_out   <= acc;
      store_out <= '0;
      dest_out  <= dest;
      zero_out  <= (acc == '0);
    end else if (mul_start || state == MUL) begin
      WB_out    <= '0;
      MEM_out   <= '0;
      alu_out   <= '0;
      store_out <= '0;
      dest_out  <= '0;
      zero_out  <= 1'b1;
    end else begin
      WB_out    <= ie_wb;
      MEM_out   <= ie_mem;
      alu_out   <= alu_res;
      store_out <= fwd_b;
      dest_out  <= dest;
      zero_out  <= (alu_res == '0);
    end
  end
endmodule

// File: tb/tb_execute_stage.sv
// tb_execute_stage: directed test-plan cases followed by randomized traffic,
// all checked against a transaction-level reference model of the stage.
module tb_execute_stage;
  localparam int MULN = 32;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        flush_in;
  logic [1:0]  WB_in;
  logic [2:0]  MEM_in;
  logic [3:0]  EXE_in;
  logic [4:0]  RS_in, RT_in, RD_in;
  logic [31:0] dataA_in, dataB_in, imm_in;
  logic        wb_regwrite_in;
  logic [4:0]  wb_rd_in;
  logic [31:0] wb_data_in;
  logic        busy_out;
  logic [1:0]  WB_out;
  logic [2:0]  MEM_out;
  logic [31:0] alu_out, store_out;
  logic [4:0]  dest_out;
  logic        zero_out;

  execute_stage #(.WIDTH(32), .MUL_CYCLES(MULN)) dut (
    .clk(clk), .rst(rst), .flush_in(flush_in),
    .WB_in(WB_in), .MEM_in(MEM_in), .EXE_in(EXE_in),
    .RS_in(RS_in), .RT_in(RT_in), .RD_in(RD_in),
    .dataA_in(dataA_in), .dataB_in(dataB_in), .imm_in(imm_in),
    .wb_regwrite_in(wb_regwrite_in), .wb_rd_in(wb_rd_in), .wb_data_in(wb_data_in),
    .busy_out(busy_out), .WB_out(WB_out), .MEM_out(MEM_out),
    .alu_out(alu_out), .store_out(store_out), .dest_out(dest_out), .zero_out(zero_out)
  );

  typedef struct {
    logic [1:0]  wb;
    logic [2:0]  mem;
    logic [3:0]  exe;
    logic [4:0]  rs, rt, rd;
    logic [31:0] a, b, imm;
  } bundle_t;

  // expected EX/MEM contents plus which fields are defined
  typedef struct {
    logic [1:0]  wb;
    logic [2:0]  mem;
    logic [31:0] alu, store;
    logic [4:0]  dest;
    logic        zero;
    bit          c_alu, c_dest, c_zero, c_store;
  } exm_t;

  // scoreboard counters
  int n_total = 0;
  int n_bad   = 0;

  // reference model state
  bundle_t     m_ie;
  exm_t        m_ex;
  int          m_left;   // edges until the pending product retires
  logic [31:0] m_prod;
  bit          m_took;   // last edge accepted the upstream bundle

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bundle_t mk(input logic [1:0] wb, input logic [2:0] mem, input logic [3:0] exe,
                                 input int rs, input int rt, input int rd,
                                 input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm);
    bundle_t x;
    x.wb = wb; x.mem = mem; x.exe = exe;
    x.rs = 5'(rs); x.rt = 5'(rt); x.rd = 5'(rd);
    x.a = a; x.b = b; x.imm = imm;
    return x;
  endfunction

  function automatic bundle_t nop();
    return mk(2'b00, 3'b000, 4'b0000, 0, 0, 0, 32'h0, 32'h0, 32'h0);
  endfunction

  function automatic bundle_t rand_bundle();
    bundle_t x;
    logic [5:0] fn [8] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00, 6'h18, 6'h3F};
    x.wb  = 2'($urandom_range(0, 3));
    x.mem = 3'($urandom_range(0, 7));
    x.exe = 4'($urandom_range(0, 15));
    x.rs  = 5'($urandom_range(0, 7));
    x.rt  = 5'($urandom_range(0, 7));
    x.rd  = 5'($urandom_range(0, 7));
    x.a   = $urandom;
    x.b   = ($urandom_range(0, 3) == 0) ? x.a : $urandom;
    x.imm = $urandom;
    x.imm[5:0] = fn[$urandom_range(0, 7)];
    return x;
  endfunction

  task automatic drive(input bundle_t x, input logic fl);
    WB_in = x.wb; MEM_in = x.mem; EXE_in = x.exe;
    RS_in = x.rs; RT_in = x.rt; RD_in = x.rd;
    dataA_in = x.a; dataB_in = x.b; imm_in = x.imm;
    flush_in = fl;
  endtask

  // Operand value the instruction actually sees: the newest in-flight write
  // to that register wins; r0 is never written by anyone.
  function automatic logic [31:0] operand(input logic [4:0] idx, input logic [31:0] latched);
    if (idx == 5'd0) return latched;
    if (m_ex.wb[1] && m_ex.dest == idx) return m_ex.alu;
    if (wb_regwrite_in && wb_rd_in == idx) return wb_data_in;
    return latched;
  endfunction

  function automatic logic [31:0] alu_ref(input logic [1:0] op, input logic [31:0] imm,
                                          input logic [31:0] a, input logic [31:0] b);
    case (op)
      2'b00: return a + b;
      2'b01: return a - b;
      2'b11: return a | imm;
      default: begin
        case (imm[5:0])
          6'h20: return a + b;
          6'h22: return a - b;
          6'h24: return a & b;
          6'h25: return a | b;
          6'h2A: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          6'h00: return b << imm[10:6];
          default: return 32'd0;
        endcase
      end
    endcase
  endfunction

  function automatic exm_t bubble_ex(input bit known_zero);
    exm_t e;
    e = '{default: 0};
    e.c_alu = known_zero;
    return e;
  endfunction

  // Advance the model by one clock edge using the current input values.
  task automatic model_edge();
    logic [31:0] fa, fb, bb;
    exm_t nx;
    if (rst) begin
      m_ie = nop();
      m_ex = '{default: 0};
      m_ex.c_alu = 1; m_ex.c_dest = 1; m_ex.c_zero = 1; m_ex.c_store = 1;
      m_left = 0;
      m_took = 1;
      return;
    end
    fa = operand(m_ie.rs, m_ie.a);
    fb = operand(m_ie.rt, m_ie.b);
    m_took = 0;
    if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        nx = '{default: 0};
        nx.wb = m_ie.wb; nx.mem = m_ie.mem; nx.alu = m_prod;
        nx.dest = m_ie.exe[3] ? m_ie.rd : m_ie.rt;
        nx.zero = (m_prod == 32'd0);
        nx.c_alu = 1; nx.c_dest = 1; nx.c_zero = 1;
        m_ie = nop();
      end else begin
        nx = bubble_ex(1);
      end
    end else if (m_ie.exe[2:1] == 2'b10 && m_ie.imm[5:0] == 6'h18) begin
      m_prod = fa * fb;
      m_left = MULN + 1;
      nx = bubble_ex(1);
    end else begin
      bb = m_ie.exe[0] ? m_ie.imm : fb;
      nx.wb = m_ie.wb; nx.mem = m_ie.mem;
      nx.alu = alu_ref(m_ie.exe[2:1], m_ie.imm, fa, bb);
      nx.store = fb;
      nx.dest = m_ie.exe[3] ? m_ie.rd : m_ie.rt;
      nx.zero = (nx.alu == 32'd0);
      nx.c_alu = (m_ie.wb != 0) || (m_ie.mem != 0);
      nx.c_dest = nx.c_alu; nx.c_zero = nx.c_alu; nx.c_store = nx.c_alu;
      m_ie.wb  = flush_in ? 2'b0 : WB_in;
      m_ie.mem = flush_in ? 3'b0 : MEM_in;
      m_ie.exe = flush_in ? 4'b0 : EXE_in;
      m_ie.rs = RS_in; m_ie.rt = RT_in; m_ie.rd = RD_in;
      m_ie.a = dataA_in; m_ie.b = dataB_in; m_ie.imm = imm_in;
      m_took = 1;
    end
    m_ex = nx;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    check("busy", 32'(busy_out), 32'(m_left > 0));
    check("wb", 32'(WB_out), 32'(m_ex.wb));
    check("mem", 32'(MEM_out), 32'(m_ex.mem));
    if (m_ex.c_alu)   check("alu", alu_out, m_ex.alu);
    if (m_ex.c_dest)  check("dest", 32'(dest_out), 32'(m_ex.dest));
    if (m_ex.c_zero)  check("zero", 32'(zero_out), 32'(m_ex.zero));
    if (m_ex.c_store) check("store", store_out, m_ex.store);
  endtask

  int busy_n;

  initial begin
    m_ie = nop();
    m_ex = '{default: 0};
    m_left = 0;
    m_prod = 0;
    m_took = 1;
    rst = 1'b1;
    drive(nop(), 1'b0);
    wb_regwrite_in = 1'b0; wb_rd_in = 5'd0; wb_data_in = 32'd0;
    tick();
    tick();
    rst = 1'b0;

    // forwarding priority: EX/MEM beats MEM/WB
    drive(mk(2'b10, 3'b000, 4'b1100, 1, 2, 3, 32'd5, 32'd7, 32'h20), 1'b0);
    tick();
    drive(mk(2'b10, 3'b000, 4'b1100, 3, 1, 4, 32'd0, 32'd5, 32'h22), 1'b0);
    wb_regwrite_in = 1'b1; wb_rd_in = 5'd3; wb_data_in = 32'd99;
    tick();
    check("fwd_add", alu_out, 32'd12);
    drive(nop(), 1'b0);
    tick();
    check("fwd_prio", alu_out, 32'd7);
    wb_regwrite_in = 1'b0;

    // register zero never forwards
    drive(mk(2'b10, 3'b000, 4'b1100, 1, 2, 0, 32'd5, 32'd7, 32'h20), 1'b0);
    tick();
    drive(mk(2'b10, 3'b000, 4'b1100, 0, 2, 5, 32'd40, 32'd2, 32'h20), 1'b0);
    wb_regwrite_in = 1'b1; wb_rd_in = 5'd0; wb_data_in = 32'd77;
    tick();
    drive(nop(), 1'b0);
    tick();
    check("r0_nofwd", alu_out, 32'd42);
    wb_regwrite_in = 1'b0;

    // lw address and beq compare
    drive(mk(2'b11, 3'b010, 4'b0001, 1, 9, 0, 32'h100, 32'h0, 32'hFFFF_FFFC), 1'b0);
    tick();
    drive(mk(2'b00, 3'b100, 4'b0010, 6, 7, 0, 32'd5, 32'd5, 32'h0), 1'b0);
    tick();
    check("lw_addr", alu_out, 32'h0000_00FC);
    check("lw_mem", 32'(MEM_out), 32'd2);
    drive(nop(), 1'b0);
    tick();
    check("beq_zero", 32'(zero_out), 32'd1);

    // slt signed, sll by 31
    drive(mk(2'b10, 3'b000, 4'b1100, 1, 2, 3, 32'hFFFF_FFFF, 32'd1, 32'h2A), 1'b0);
    tick();
    drive(mk(2'b10, 3'b000, 4'b1100, 0, 2, 4, 32'd0, 32'd1, 32'h0000_07C0), 1'b0);
    tick();
    check("slt", alu_out, 32'd1);
    drive(nop(), 1'b0);
    tick();
    check("sll", alu_out, 32'h8000_0000);

    // multiply, with the following add held upstream
    drive(mk(2'b10, 3'b000, 4'b1100, 1, 2, 8, 32'h0001_0001, 32'h0001_0001, 32'h18), 1'b0);
    tick();
    drive(mk(2'b10, 3'b000, 4'b1100, 3, 4, 9, 32'd3, 32'd4, 32'h20), 1'b0);
    tick();
    busy_n = 0;
    for (int i = 0; i < 40 && busy_out; i++) begin
      busy_n++;
      tick();
    end
    check("mul_busy_cycles", 32'(busy_n), 32'd33);
    check("mul_prod", alu_out, 32'h0002_0001);
    check("mul_wb", 32'(WB_out), 32'd2);
    tick();
    check("post_mul_bubble", 32'(WB_out), 32'd0);
    drive(nop(), 1'b0);
    tick();
    check("held_exec", alu_out, 32'd7);
    check("held_exec_wb", 32'(WB_out), 32'd2);
    tick();
    check("held_once", 32'(WB_out), 32'd0);

    // reset at multiply iteration 10
    drive(mk(2'b10, 3'b000, 4'b1100, 1, 2, 8, 32'd123, 32'd456, 32'h18), 1'b0);
    tick();
    drive(nop(), 1'b0);
    tick();
    repeat (10) tick();
    rst = 1'b1;
    tick();
    check("rst_busy", 32'(busy_out), 32'd0);
    check("rst_alu", alu_out, 32'd0);
    check("rst_wb", 32'(WB_out), 32'd0);
    rst = 1'b0;

    // flush of a valid add
    drive(mk(2'b10, 3'b001, 4'b1100, 1, 2, 3, 32'd1, 32'd2, 32'h20), 1'b1);
    tick();
    drive(nop(), 1'b0);
    tick();
    check("flush_wb", 32'(WB_out), 32'd0);
    check("flush_mem", 32'(MEM_out), 32'd0);

    // flush wins over a mult capture
    drive(mk(2'b10, 3'b000, 4'b1100, 1, 2, 3, 32'd6, 32'd7, 32'h18), 1'b1);
    tick();
    drive(nop(), 1'b0);
    tick();
    check("flush_mul_busy", 32'(busy_out), 32'd0);
    tick();
    check("flush_mul_busy2", 32'(busy_out), 32'd0);

    // randomized traffic; upstream advances only when its bundle was taken
    m_took = 1;
    for (int c = 0; c < 2000; c++) begin
      if (m_took) drive(rand_bundle(), ($urandom_range(0, 9) == 0));
      wb_regwrite_in = 1'($urandom_range(0, 1));
      wb_rd_in       = 5'($urandom_range(0, 7));
      wb_data_in     = $urandom;
      rst            = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
